// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: two-master round-robin arbiter serialising requests onto a single-port memory
module mem_rr_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_wr_rd,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_wr_rd,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_wr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t state;
    logic   last_grant;
    logic   gnt;
    logic   sel;

    // pick a master: the lone requester, or the one not granted last time on a tie
    always_comb begin
        sel        = (req0_valid && req1_valid) ? !last_grant : req1_valid;
        req0_ready = state == IDLE && req0_valid && !sel;
        req1_ready = state == IDLE && req1_valid && sel;
    end

    // accept one request, present it to memory, then route any read data back
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            mem_valid  <= 1'b0;
            mem_wr_rd  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        gnt       <= sel;
                        mem_valid <= 1'b1;
                        mem_wr_rd <= sel ? req1_wr_rd : req0_wr_rd;
                        mem_addr  <= sel ? req1_addr : req0_addr;
                        mem_wdata <= sel ? req1_wdata : req0_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_valid  <= 1'b0;
                        last_grant <= gnt;
                        state      <= mem_wr_rd ? IDLE : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (gnt) begin
                        rsp1_valid <= 1'b1;
                        rsp1_rdata <= mem_rdata;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_rdata <= mem_rdata;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: scoreboard bench with directed latency/fairness/reset cases and random traffic
module tb_mem_rr_arbiter;
    typedef struct packed {
        logic       m;
        logic       w;
        logic [5:0] a;
        logic [7:0] d;
    } txn_t;
    typedef struct packed {
        logic       m;
        logic [7:0] d;
    } rsp_t;

    logic clk, rst;
    logic rv[2], rw[2];
    logic [5:0] ra[2];
    logic [7:0] rd[2];
    logic r0, r1;
    logic rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic mem_valid, mem_ready, mem_wr_rd;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [7:0] mem[64];
    logic [7:0] ref_mem[64];
    logic [1:0] rmode;

    txn_t mem_q[$];
    rsp_t rsp_q[$];
    logic glog[$];
    logic [5:0] alog[$];
    logic m_last, g;
    logic [7:0] hold0, hold1;
    txn_t e;
    rsp_t x;
    int n_chk = 0, n_fail = 0;

    mem_rr_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(rv[0]), .req0_ready(r0), .req0_wr_rd(rw[0]), .req0_addr(ra[0]), .req0_wdata(rd[0]),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(rv[1]), .req1_ready(r1), .req1_wr_rd(rw[1]), .req1_addr(ra[1]), .req1_wdata(rd[1]),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr_rd(mem_wr_rd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int m, input logic w, input logic [5:0] a, input logic [7:0] d);
        int k;
        rv[m] = 1; rw[m] = w; ra[m] = a; rd[m] = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(m == 1 ? r1 : r0) && k < 500);
        chk("send_accepted", k < 500, 1);
        tick;
        rv[m] = 0;
    endtask

    // memory model: one-cycle read latency, garbage on rdata otherwise
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
        end else if (mem_valid && mem_ready) begin
            if (mem_wr_rd) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end else begin
            mem_rdata <= 8'($urandom);
        end
    end

    // memory ready: 0, 1, or random per cycle
    always @(posedge clk) begin
        #1;
        mem_ready = (rmode == 2'd2) ? 1'($urandom_range(0, 1)) : rmode[0];
    end

    // scoreboard: predict grants and memory traffic, then match responses
    always @(negedge clk) begin
        if (rst) begin
            mem_q.delete();
            rsp_q.delete();
            m_last = 1;
            hold0 = 0;
            hold1 = 0;
            for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        end else begin
            chk("one_ready", r0 && r1, 0);
            chk("ready_busy", (r0 || r1) && mem_valid, 0);
            if (mem_valid) begin
                chk("mem_pending", mem_q.size() > 0, 1);
                if (mem_q.size() > 0) begin
                    e = mem_q[0];
                    chk("mem_wr_rd", mem_wr_rd, e.w);
                    chk("mem_addr", mem_addr, e.a);
                    if (e.w) chk("mem_wdata", mem_wdata, e.d);
                    if (mem_ready) begin
                        void'(mem_q.pop_front());
                        glog.push_back(e.m);
                        alog.push_back(mem_addr);
                        if (e.w) ref_mem[e.a] = e.d;
                        else rsp_q.push_back('{e.m, ref_mem[e.a]});
                    end
                end
            end
            if ((r0 && rv[0]) || (r1 && rv[1])) begin
                g = r1 && rv[1];
                chk("grant", g, (rv[0] && rv[1]) ? !m_last : rv[1]);
                m_last = g;
                mem_q.push_back('{g, rw[g], ra[g], rd[g]});
            end
            if (rsp0_valid || rsp1_valid) begin
                chk("rsp_pending", rsp_q.size() > 0, 1);
                chk("rsp_both", rsp0_valid && rsp1_valid, 0);
                if (rsp_q.size() > 0) begin
                    x = rsp_q.pop_front();
                    chk("rsp_master", rsp1_valid, x.m);
                    chk("rsp_rdata", x.m ? rsp1_rdata : rsp0_rdata, x.d);
                    if (x.m) hold1 = x.d;
                    else hold0 = x.d;
                end
            end
            if (!rsp0_valid) chk("rsp0_hold", rsp0_rdata, hold0);
            if (!rsp1_valid) chk("rsp1_hold", rsp1_rdata, hold1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; rmode = 2'd1;
        rv[0] = 0; rv[1] = 0; rw[0] = 0; rw[1] = 0;
        ra[0] = 0; ra[1] = 0; rd[0] = 0; rd[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {mem_valid, mem_wr_rd, mem_addr, mem_wdata, rsp0_valid, rsp0_rdata,
                        rsp1_valid, rsp1_rdata, r0, r1}, 64'd0);

        // write then read-back latency
        tick; rst = 0;
        rv[0] = 1; rw[0] = 1; ra[0] = 6'd5; rd[0] = 8'hA5;
        @(negedge clk); chk("wr_ready0", r0, 1);
        tick; rv[0] = 0; rv[1] = 1; rw[1] = 0; ra[1] = 6'd5; rd[1] = 8'h00;
        @(negedge clk);
        chk("wr_issue", {mem_valid, mem_wr_rd, mem_addr, mem_wdata}, {1'b1, 1'b1, 6'd5, 8'hA5});
        chk("busy_ready1", r1, 0);
        tick;
        @(negedge clk);
        chk("wr_done_idle", {mem_valid, r1}, 2'b01);
        tick; rv[1] = 0;
        @(negedge clk); chk("rd_issue", {mem_valid, mem_wr_rd, mem_addr}, {1'b1, 1'b0, 6'd5});
        tick;
        @(negedge clk); chk("rd_wait", {rsp0_valid, rsp1_valid}, 2'b00);
        tick;
        @(negedge clk);
        chk("rd_rsp", {rsp1_valid, rsp1_rdata, rsp0_valid}, {1'b1, 8'hA5, 1'b0});
        tick;
        @(negedge clk); chk("rd_pulse_end", {rsp0_valid, rsp1_valid}, 2'b00);

        // continuous contention: 6 writes per master
        glog.delete(); alog.delete();
        tick;
        fork
            begin
                for (int i = 0; i < 6; i++) send(0, 1, 6'(i), 8'($urandom));
            end
            begin
                for (int j = 0; j < 6; j++) send(1, 1, 6'(j), 8'($urandom));
            end
        join
        repeat (3) tick;
        chk("contend_count", glog.size(), 12);
        for (int k = 0; k < 12 && k < glog.size(); k++) begin
            chk("contend_grant", glog[k], k % 2);
            chk("contend_addr", alog[k], k / 2);
        end

        // memory stalls for 4 cycles
        rmode = 2'd0;
        tick;
        rv[0] = 1; rw[0] = 1; ra[0] = 6'd9; rd[0] = 8'h3C;
        rv[1] = 1; rw[1] = 1; ra[1] = 6'd10; rd[1] = 8'h5A;
        @(negedge clk); chk("stall_grant", {r0, r1}, 2'b10);
        tick; rv[0] = 0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("stall_hold", {mem_valid, mem_wr_rd, mem_addr, mem_wdata}, {1'b1, 1'b1, 6'd9, 8'h3C});
            chk("stall_ready", {r0, r1}, 2'b00);
            if (s < 3) tick;
        end
        rmode = 2'd1;
        tick;
        @(negedge clk); chk("stall_release", mem_valid, 1);
        tick;
        @(negedge clk); chk("stall_done", {mem_valid, r1}, 2'b01);
        tick; rv[1] = 0;
        repeat (3) tick;

        // reset while waiting for read data
        rv[0] = 1; rw[0] = 0; ra[0] = 6'd9;
        @(negedge clk); chk("rstrd_ready0", r0, 1);
        tick; rv[0] = 0;
        tick; rst = 1;
        @(negedge clk);
        tick;
        @(negedge clk);
        chk("rstrd_out", {mem_valid, mem_wr_rd, mem_addr, mem_wdata, rsp0_valid, rsp0_rdata,
                          rsp1_valid, rsp1_rdata}, 64'd0);
        tick; rst = 0;
        rv[0] = 1; rw[0] = 1; ra[0] = 6'd1; rd[0] = 8'h11;
        rv[1] = 1; rw[1] = 1; ra[1] = 6'd2; rd[1] = 8'h22;
        @(negedge clk); chk("rstrd_first", {r0, r1, rsp0_valid}, 3'b100);
        tick; rv[0] = 0;
        send(1, 1, 6'd2, 8'h22);

        // random traffic with random memory back-pressure
        rmode = 2'd2;
        tick;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) tick;
                    send(0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom));
                end
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    repeat ($urandom_range(0, 2)) tick;
                    send(1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom));
                end
            end
        join
        rmode = 2'd1;
        for (int k = 0; k < 100 && (mem_q.size() != 0 || rsp_q.size() != 0); k++) tick;
        repeat (3) tick;
        chk("drain_mem", mem_q.size(), 0);
        chk("drain_rsp", rsp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Two-requester round-robin arbiter sitting directly upstream of the single-port memory block.
- Accepts read/write requests from two masters over valid/ready and serialises them onto the memory request port, one transaction at a time.
- Routes each read response back to the master that issued the read.
- Gives the memory a second traffic source so the environment can exercise contention.

Parameters:
- ADDR_WIDTH, 6, memory address width.
- DATA_WIDTH, 8, memory data width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  master 0 request valid.
- req0_ready  output  1  master 0 request accepted this cycle.
- req0_wr_rd  input  1  master 0 request type: 1 = write, 0 = read.
- req0_addr  input  ADDR_WIDTH  master 0 address.
- req0_wdata  input  DATA_WIDTH  master 0 write data.
- rsp0_valid  output  1  one-cycle pulse: master 0 read data valid.
- rsp0_rdata  output  DATA_WIDTH  master 0 read data.
- req1_valid, req1_ready, req1_wr_rd, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: identical to the master 0 ports, for master 1.
- mem_valid  output  1  request to memory.
- mem_ready  input  1  memory accepts request this cycle.
- mem_wr_rd  output  1  request type to memory.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  memory read data, valid exactly 1 cycle after a read handshake.

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE; last_grant = 1, so master 0 wins the first tie.
  - mem_valid, mem_wr_rd, mem_addr, mem_wdata, rsp0/1_valid and rsp0/1_rdata all = 0.
  - Any in-flight transaction is abandoned: no memory request continues and no response is produced.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - reqN_ready is combinational: high only in IDLE, and only for the selected master.
  - Selection when only one reqN_valid is high: that master.
  - Selection when both are high: the master != last_grant.
  - On acceptance (valid && ready) the block latches wr_rd/addr/wdata and records the granted index, then moves to ISSUE.
  - At most one ready is high per cycle. Ready is never high outside IDLE.
- ISSUE:
  - mem_valid = 1; mem_wr_rd/addr/wdata are driven from the latched values and held stable until mem_ready.
  - On mem_valid && mem_ready:
    - mem_valid drops on the next cycle.
    - last_grant updates to the granted index.
    - Write: go to IDLE.
    - Read: go to WAIT_RD.
- WAIT_RD:
  - At the edge ending this state, capture mem_rdata into rspN_rdata of the granted master and set rspN_valid = 1 for exactly one cycle.
  - Go to IDLE.
  - A new request may be accepted in the same cycle rspN_valid is high.
- Latency with mem_ready tied high (accept at cycle T):
  - mem_valid at T+1.
  - Read: rdata sampled at T+2, rsp_valid at T+3.
  - Write: block is back in IDLE at T+2.
- Throughput: one transaction per 2 cycles for writes and 3 cycles for reads.
- rspN_rdata holds its value until that master's next read response. The other master's response registers are unaffected.
- mem_ready while mem_valid = 0 is ignored.
- Requests whose valid deasserts before acceptance are simply not taken. No buffering beyond the single latched request.
- Fairness: under continuous contention, grants strictly alternate 0, 1, 0, 1, ...

Test Plan:
- Reset, then master 0 writes addr 5, data 0xA5 with mem_ready high -> req0_ready at cycle T, mem_valid with addr 5, wdata 0xA5, wr_rd 1 at T+1, FSM idle at T+2, no rsp pulse.
- Master 1 reads addr 5 after the previous write, memory model returns 0xA5 -> rsp1_valid single pulse with rsp1_rdata = 0xA5 at T+3; rsp0_valid stays 0.
- Both masters hold valid continuously for 6 writes each (addr = index) -> grant order 0,1,0,1,...; mem_addr sequence shows strict alternation; 12 memory writes total.
- mem_ready held low 4 cycles during ISSUE -> mem_valid/addr/wdata stable for all 4 cycles; req0/1_ready low throughout; transaction completes the cycle after mem_ready rises.
- rst asserted during WAIT_RD of a read -> next cycle all outputs 0, no rsp pulse, state IDLE; the first request after release goes to master 0 when both are valid.
